// File: rtl/mul_pipe.sv
// mul_pipe: three-stage radix-4 Booth multiplier with sideband tag and
// valid/ready handshake. Define MUL_PIPE_ACC_EN to enable MADD/MSUB, which
// carries the accumulator operand through S1/S2 into the final adder.
module mul_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               flush_cause,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               s,
    input  logic [1:0]         op,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [TAG_W-1:0]   tag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z,
    output logic [TAG_W-1:0]   tag_out
);
    localparam int PW   = 2 * WIDTH;
    localparam int NPP  = WIDTH / 2 + 1;
    localparam int NROW = NPP + 1;
    localparam int NLO  = NROW / 2;
    localparam int NHI  = NROW - NLO;

    logic               r_v1, r_v2, r_v3;
    logic [TAG_W-1:0]   r_tag1, r_tag2, r_tagOut;
    logic [PW-1:0]      r_sum1, r_car1, r_sum2, r_car2, r_z;
    logic [PW-1:0]      r_hi1 [NHI];
`ifdef MUL_PIPE_ACC_EN
    logic [1:0]         r_op1, r_op2;
    logic [PW-1:0]      r_acc1, r_acc2;
`else
    logic               w_unusedAcc;
    assign w_unusedAcc = ^{op, acc};
`endif

    logic w_kill, w_stall, w_adv;
    assign w_kill    = flush & flush_cause;
    assign w_stall   = r_v3 & ~out_ready;
    assign w_adv     = ~w_kill & ~w_stall;
    assign in_ready  = ~reset & w_adv;
    assign out_valid = r_v3;
    assign z         = r_z;
    assign tag_out   = r_tagOut;

    // 3:2 compressor on full product-width vectors, returns {sum, carry}
    function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] a,
                                            input logic [PW-1:0] b,
                                            input logic [PW-1:0] c);
        csa = {a ^ b ^ c, ((a & b) | (a & c) | (b & c)) << 1};
    endfunction

    logic [WIDTH:0]   w_xe;
    logic [WIDTH+1:0] w_ye;
    logic [WIDTH+2:0] w_yp;
    logic [PW-1:0]    w_xw;
    assign w_xe = {s & x[WIDTH-1], x};
    assign w_ye = {{2{s & y[WIDTH-1]}}, y};
    assign w_yp = {w_ye, 1'b0};
    assign w_xw = {{(PW-WIDTH-1){w_xe[WIDTH]}}, w_xe};

    logic [PW-1:0] w_rows [NROW];

    // Booth-encode y; negative digits are inverted here and their +1 goes into the last (correction) row
    always_comb begin
        logic [2:0]    b;
        logic [PW-1:0] m;
        logic          one, two, neg;
        b   = '0;
        m   = '0;
        one = 1'b0;
        two = 1'b0;
        neg = 1'b0;
        w_rows[NPP] = '0;
        for (int i = 0; i < NPP; i++) begin
            b   = w_yp[2*i +: 3];
            one = b[0] ^ b[1];
            two = (b == 3'b011) | (b == 3'b100);
            neg = b[2] & ~(b[1] & b[0]);
            m   = one ? w_xw : (two ? {w_xw[PW-2:0], 1'b0} : '0);
            w_rows[i] = (neg ? ~m : m) << (2*i);
            w_rows[NPP][2*i] = neg;
        end
    end

    logic [PW-1:0] w_sum1, w_car1;

    // First-half carry-save reduction of the lower rows, done before the S1 register
    always_comb begin
        logic [2*PW-1:0] t;
        t      = '0;
        w_sum1 = w_rows[0];
        w_car1 = '0;
        for (int i = 1; i < NLO; i++) begin
            t      = csa(w_sum1, w_car1, w_rows[i]);
            w_sum1 = t[2*PW-1:PW];
            w_car1 = t[PW-1:0];
        end
    end

    // S1 register: partial sum/carry pair plus the rows not yet compressed
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1   <= 1'b0;
            r_tag1 <= '0;
            r_sum1 <= '0;
            r_car1 <= '0;
            for (int j = 0; j < NHI; j++) r_hi1[j] <= '0;
`ifdef MUL_PIPE_ACC_EN
            r_op1  <= '0;
            r_acc1 <= '0;
`endif
        end else if (w_adv) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_tag1 <= tag_in;
                r_sum1 <= w_sum1;
                r_car1 <= w_car1;
                for (int j = 0; j < NHI; j++) r_hi1[j] <= w_rows[NLO+j];
`ifdef MUL_PIPE_ACC_EN
                r_op1  <= op;
                r_acc1 <= acc;
`endif
            end
        end else if (w_kill) begin
            r_v1 <= 1'b0;
        end
    end

    logic [PW-1:0] w_sum2, w_car2;

    // Second-half carry-save reduction down to the final sum/carry pair
    always_comb begin
        logic [2*PW-1:0] t;
        t      = '0;
        w_sum2 = r_sum1;
        w_car2 = r_car1;
        for (int j = 0; j < NHI; j++) begin
            t      = csa(w_sum2, w_car2, r_hi1[j]);
            w_sum2 = t[2*PW-1:PW];
            w_car2 = t[PW-1:0];
        end
    end

    // S2 register: final redundant product and the latched op/acc
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v2   <= 1'b0;
            r_tag2 <= '0;
            r_sum2 <= '0;
            r_car2 <= '0;
`ifdef MUL_PIPE_ACC_EN
            r_op2  <= '0;
            r_acc2 <= '0;
`endif
        end else if (w_adv) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_tag2 <= r_tag1;
                r_sum2 <= w_sum2;
                r_car2 <= w_car2;
`ifdef MUL_PIPE_ACC_EN
                r_op2  <= r_op1;
                r_acc2 <= r_acc1;
`endif
            end
        end else if (w_kill) begin
            r_v2 <= 1'b0;
        end
    end

    logic [PW-1:0] w_prod, w_zNext;

    // Carry-propagate add, then optional accumulate (reserved op behaves as MUL)
    always_comb begin
        w_prod  = r_sum2 + r_car2;
        w_zNext = w_prod;
`ifdef MUL_PIPE_ACC_EN
        case (r_op2)
            2'b01:   w_zNext = r_acc2 + w_prod;
            2'b10:   w_zNext = r_acc2 - w_prod;
            default: w_zNext = w_prod;
        endcase
`endif
    end

    // S3 register: z and tag only change when a valid operation lands here
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v3     <= 1'b0;
            r_z      <= '0;
            r_tagOut <= '0;
        end else if (w_adv) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_z      <= w_zNext;
                r_tagOut <= r_tag2;
            end
        end else if (w_kill) begin
            r_v3 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: scoreboard bench for mul_pipe (WIDTH=32). Expected results are
// pushed on accept and popped by an independent monitor on each handshake.
module tb_mul_pipe;
    localparam int WIDTH = 32;
    localparam int TAG_W = 5;

    logic               clk = 1'b0;
    logic               reset, flush, flush_cause, in_valid, in_ready, s;
    logic               out_valid, out_ready;
    logic [WIDTH-1:0]   x, y;
    logic [1:0]         op;
    logic [2*WIDTH-1:0] acc, z;
    logic [TAG_W-1:0]   tag_in, tag_out;

    always #5 clk = ~clk;

    mul_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .flush_cause(flush_cause),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .s(s),
        .op(op), .acc(acc), .tag_in(tag_in), .out_valid(out_valid),
        .out_ready(out_ready), .z(z), .tag_out(tag_out)
    );

    typedef struct {
        logic        s;
        logic [1:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] acc;
        logic [63:0] zMul;
        logic [63:0] zAcc;
    } vec_t;

    typedef struct packed {
        logic [63:0] z;
        logic [4:0]  tag;
        int          acceptCycle;
        logic        chkLat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    // Counts rising edges so the monitor can measure latency
    initial forever begin
        @(posedge clk);
        cycle++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h (cycle %0d)", name, actual, required, cycle);
        end
    endtask

    function automatic vec_t mkVec(logic sv, logic [1:0] opv, logic [31:0] xv, logic [31:0] yv,
                                   logic [63:0] accv, logic [63:0] zm, logic [63:0] za);
        vec_t v;
        v.s = sv; v.op = opv; v.x = xv; v.y = yv; v.acc = accv; v.zMul = zm; v.zAcc = za;
        return v;
    endfunction

    function automatic logic [63:0] expOf(vec_t v);
`ifdef MUL_PIPE_ACC_EN
        return v.zAcc;
`else
        return v.zMul;
`endif
    endfunction

    // Drive one operation, retrying while in_ready is low; push expectation on accept
    task automatic applyStimulus(input vec_t v, input logic [4:0] tag, input logic chkLat);
        int   tries;
        bit   done;
        exp_t e;
        tries = 0;
        done = 1'b0;
        in_valid = 1'b1; s = v.s; op = v.op; x = v.x; y = v.y; acc = v.acc; tag_in = tag;
        while (!done) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                e.z = expOf(v); e.tag = tag; e.acceptCycle = cycle; e.chkLat = chkLat;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
            if (!done) begin
                tries++;
                if (tries > 20) begin
                    checks++; errors++;
                    $display("[TB] FAIL accept timeout: tag %0d never accepted", tag);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: pops on each handshake and checks hold-stability while stalled
    initial begin
        logic        prevStall;
        logic [63:0] prevZ;
        logic [4:0]  prevTag;
        exp_t        e;
        prevStall = 1'b0;
        prevZ = '0;
        prevTag = '0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (prevStall) begin
                    checkOutput("stall z hold", z, prevZ);
                    checkOutput("stall tag hold", 64'(tag_out), 64'(prevTag));
                end
                if (out_ready === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL unexpected result: z=%h tag=%0d, none required", z, tag_out);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("result z", z, e.z);
                        checkOutput("result tag", 64'(tag_out), 64'(e.tag));
                        if (e.chkLat) checkOutput("latency", 64'(cycle - e.acceptCycle), 64'd3);
                    end
                    prevStall = 1'b0;
                end else begin
                    prevStall = 1'b1;
                    prevZ = z;
                    prevTag = tag_out;
                end
            end else begin
                prevStall = 1'b0;
            end
        end
    end

    // Directed stimulus sequence
    initial begin
        logic [63:0] stallExp [4];
        int          sent;
        exp_t        e;
        stallExp[0] = 64'h21; stallExp[1] = 64'h30; stallExp[2] = 64'h41; stallExp[3] = 64'h54;

        vecs[0]  = mkVec(1, 2'b00, 32'hFFFFFFFE, 32'h3,        64'h0, 64'hFFFFFFFFFFFFFFFA, 64'hFFFFFFFFFFFFFFFA);
        vecs[1]  = mkVec(0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 64'hFFFFFFFE00000001, 64'hFFFFFFFE00000001);
        vecs[2]  = mkVec(1, 2'b00, 32'h80000000, 32'h80000000, 64'h0, 64'h4000000000000000, 64'h4000000000000000);
        vecs[3]  = mkVec(0, 2'b00, 32'hFFFFFFFF, 32'h2,        64'h0, 64'h00000001FFFFFFFE, 64'h00000001FFFFFFFE);
        vecs[4]  = mkVec(1, 2'b00, 32'hFFFFFFFF, 32'h2,        64'h0, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFE);
        vecs[5]  = mkVec(1, 2'b00, 32'h7,        32'hFFFFFFFB, 64'h0, 64'hFFFFFFFFFFFFFFDD, 64'hFFFFFFFFFFFFFFDD);
        vecs[6]  = mkVec(0, 2'b00, 32'h12345678, 32'h10,       64'h0, 64'h0000000123456780, 64'h0000000123456780);
        vecs[7]  = mkVec(1, 2'b00, 32'h0,        32'hFFFFFFFF, 64'h0, 64'h0,                64'h0);
        vecs[8]  = mkVec(1, 2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h0, 64'h3FFFFFFF00000001, 64'h3FFFFFFF00000001);
        vecs[9]  = mkVec(1, 2'b00, 32'h80000000, 32'h7FFFFFFF, 64'h0, 64'hC000000080000000, 64'hC000000080000000);
        vecs[10] = mkVec(0, 2'b01, 32'h4,        32'h5,        64'h10,   64'h14, 64'h24);
        vecs[11] = mkVec(0, 2'b10, 32'hA,        32'hA,        64'h64,   64'h64, 64'h0);
        vecs[12] = mkVec(0, 2'b11, 32'h3,        32'h3,        64'h5555, 64'h9,  64'h9);
        vecs[13] = mkVec(1, 2'b10, 32'hFFFFFFFF, 32'h1,        64'h0,    64'hFFFFFFFFFFFFFFFF, 64'h1);
        vecs[14] = mkVec(0, 2'b01, 32'h1,        32'h1,        64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0);
        vecs[15] = mkVec(1, 2'b01, 32'hFFFFFFFF, 32'h3,        64'h100,  64'hFFFFFFFFFFFFFFFD, 64'hFD);

        reset = 1'b1; flush = 1'b0; flush_cause = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        s = 1'b0; op = 2'b00; x = '0; y = '0; acc = '0; tag_in = '0;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset z", z, 64'd0);
        checkOutput("reset tag_out", 64'(tag_out), 64'd0);
        checkOutput("reset in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single op: out_valid exactly one cycle, three cycles after accept
        applyStimulus(vecs[0], 5'd1, 1'b1);
        @(negedge clk); checkOutput("single ov c1", 64'(out_valid), 64'd0);
        @(negedge clk); checkOutput("single ov c2", 64'(out_valid), 64'd0);
        @(negedge clk); checkOutput("single ov c3", 64'(out_valid), 64'd1);
        @(negedge clk); checkOutput("single ov c4", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // Back-to-back directed vectors
        for (int i = 1; i < 16; i++) applyStimulus(vecs[i], 5'(i + 2), 1'b1);
        idle(6);

        // Backpressure: four ops, consumer not ready in relative cycles 3..6
        sent = 0;
        for (int rel = 1; rel <= 12; rel++) begin
            out_ready = !(rel >= 3 && rel <= 6);
            if (sent < 4) begin
                in_valid = 1'b1; s = 1'b0; op = 2'b00; acc = '0;
                x = 32'(sent + 11); y = 32'(sent + 3); tag_in = 5'(sent + 1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (rel >= 4 && rel <= 6) checkOutput("stall in_ready", 64'(in_ready), 64'd0);
            if (in_valid && in_ready === 1'b1) begin
                e.z = stallExp[sent]; e.tag = 5'(sent + 1); e.acceptCycle = cycle; e.chkLat = 1'b0;
                sb.push_back(e);
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checkOutput("stall ops accepted", 64'(sent), 64'd4);
        idle(2);

        // Exception flush kills two in-flight ops and blocks same-cycle input
        applyStimulus(vecs[1], 5'd20, 1'b1);
        applyStimulus(vecs[2], 5'd21, 1'b1);
        flush = 1'b1; flush_cause = 1'b1;
        in_valid = 1'b1; s = vecs[3].s; op = vecs[3].op; x = vecs[3].x; y = vecs[3].y; tag_in = 5'd22;
        @(negedge clk);
        checkOutput("flush in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        flush = 1'b0; flush_cause = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("flush out_valid", 64'(out_valid), 64'd0);
        end
        checkOutput("flush z unchanged", z, 64'h54);
        @(posedge clk); #1;

        // Non-exception flush has no effect
        applyStimulus(vecs[4], 5'd23, 1'b1);
        applyStimulus(vecs[5], 5'd24, 1'b1);
        flush = 1'b1; flush_cause = 1'b0;
        applyStimulus(vecs[6], 5'd25, 1'b1);
        flush = 1'b0;
        idle(6);

        // Reset mid-flight discards everything; first accept right after
        applyStimulus(vecs[8], 5'd26, 1'b1);
        applyStimulus(vecs[9], 5'd27, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checkOutput("post-reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("post-reset z", z, 64'd0);
        checkOutput("post-reset in_ready", 64'(in_ready), 64'd1);
        applyStimulus(vecs[15], 5'd28, 1'b1);

        for (int k = 0; k < 30 && sb.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        idle(3);
        checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_pipe.md
MUL_PIPE -- requirements
Module: mul_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; legal values are even and 8..64; product width is 2*WIDTH.
REQ-002 Parameter TAG_W, default 5: width of the sideband tag carried with each operation.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline kill request.
- flush_cause  in  1  1 = exception; only flush=1 with flush_cause=1 kills in-flight operations.
- in_valid  in  1  operation request.
- in_ready  out  1  block accepts the operation this cycle.
- x  in  WIDTH  multiplicand.
- y  in  WIDTH  multiplier.
- s  in  1  1 = signed, 0 = unsigned.
- op  in  2  00 = MUL, 01 = MADD, 10 = MSUB, 11 = reserved (treated as MUL).
- acc  in  2*WIDTH  accumulator operand for MADD/MSUB.
- tag_in  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- z  out  2*WIDTH  result.
- tag_out  out  TAG_W  tag of the result.

Function
REQ-004 Operands SHALL be extended by one bit: x by sign (s=1) or zero (s=0); y by two bits the same way. Radix-4 Booth SHALL generate WIDTH/2+1 partial products plus a correction-bit vector, reduced by a carry-save tree.
REQ-005 The pipeline SHALL have three register stages:
- S1: operands, Booth encoding and first-half compression.
- S2: final carry-save sum/carry pair plus latched op/acc.
- S3: carry-propagate add with accumulate.
- Latency is exactly 3 cycles from accept to out_valid when there is no backpressure.
REQ-006 An operation is accepted when in_valid && in_ready; throughput is one operation per cycle.
REQ-007 Stall = out_valid && !out_ready; while stalled, all stages hold and in_ready = 0; otherwise in_ready = 1.
REQ-008 While out_valid=1 and out_ready=0, z and tag_out SHALL be held stable.
REQ-009 Results are computed modulo 2^(2*WIDTH):
- MUL: z = x*y.
- MADD: z = acc + x*y.
- MSUB: z = acc - x*y.
- Signedness of the product follows s.
REQ-010 Each stage has a valid bit; out_valid = S3 valid bit. Bubbles SHALL propagate without asserting out_valid.
REQ-011 flush=1 with flush_cause=1 SHALL clear all stage valid bits at the next edge. The same cycle's input is not accepted (in_ready = 0 that cycle). z is unchanged.
REQ-012 flush=1 with flush_cause=0 SHALL have no effect on the block.
REQ-013 Flush SHALL take priority over stall: a stalled result is discarded.
REQ-014 Operations SHALL leave in acceptance order; tag_out pairs with its own result.

Reset
REQ-015 While reset=1 at an edge, all valid bits and z SHALL clear to 0, tag_out to 0, and in_ready reads 0; reset overrides flush and handshakes.
REQ-016 Reset asserted mid-operation SHALL discard all in-flight operations; the first accept is possible in the cycle after reset deasserts.

Configuration
REQ-017 Macro MUL_PIPE_ACC_EN:
- Defined: MADD/MSUB are supported, and acc is registered in S1/S2.
- Undefined: op and acc are ignored, every operation is MUL, and no accumulator registers or adder input exist.

Verification
REQ-018 WIDTH=32, s=1, x=0xFFFFFFFE, y=3, op=MUL -> after 3 cycles z=0xFFFFFFFFFFFFFFFA, out_valid=1 for one cycle.
REQ-019 s=0, x=y=0xFFFFFFFF -> z=0xFFFFFFFE00000001; s=1, x=y=0x80000000 -> z=0x4000000000000000.
REQ-020 MUL_PIPE_ACC_EN defined:
- MADD, acc=0x10, x=4, y=5 -> z=0x24.
- MSUB, acc=0x64, x=y=10 -> z=0.
- Undefined: the same MSUB stimulus -> z=0x64.
REQ-021 Four back-to-back ops with tags 1..4, out_ready=0 for cycles 3..6:
- in_ready=0 during the stall.
- Results emerge in order 1..4 with z stable while stalled.
- No result is lost or duplicated.
REQ-022 Two ops in flight; flush=1, flush_cause=1 pulse -> no out_valid for them. The same pulse with flush_cause=0 -> both results delivered at their normal cycles.
REQ-023 reset=1 one cycle mid-flight -> out_valid=0 and z=0 next cycle; a new op accepted the cycle after reset drops yields its correct result 3 cycles later.
